// File: rtl/fir_fixed_sdiv_36s_12s_24_seq.sv
// Sequential signed divider, 36-bit dividend by 12-bit divisor, 24-bit saturated quotient.
// One restoring step per enabled clock on magnitudes, then sign/saturation fix-up in one step.
module fir_fixed_sdiv_36s_12s_24_seq #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd36,
  parameter int unsigned din1_WIDTH = 32'd12,
  parameter int unsigned dout_WIDTH = 32'd24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  dz
);

  if (din0_WIDTH != 36 || din1_WIDTH != 12 || dout_WIDTH != 24) begin : g_bad_width
    $error("fir_fixed_sdiv_36s_12s_24_seq %0d: only 36/12/24 widths are supported", ID);
  end

  localparam logic [23:0] QMax  = 24'h7F_FFFF;
  localparam logic [23:0] QMin  = 24'h80_0000;
  localparam logic [5:0]  Steps = 6'd36;

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [35:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient as bits shift in
  logic [11:0] dvs_q, dvs_d;
  logic [11:0] prem_q, prem_d;   // partial remainder, always below the divisor
  logic        sdvd_q, sdvd_d;
  logic        sq_q, sq_d;
  logic [23:0] dout_q, dout_d;
  logic [11:0] rem_q, rem_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        dz_q, dz_d;

  logic [12:0] shifted;
  logic        sub_ok;
  logic        q_ovf;
  logic [23:0] q_signed;
  logic [11:0] rem_signed;

  always_comb begin
    shifted    = {prem_q, dvd_q[35]};
    sub_ok     = shifted >= {1'b0, dvs_q};
    // A negative result may reach exactly 2^23 without saturating.
    q_ovf      = sq_q ? (dvd_q > 36'd8388608) : (dvd_q > 36'd8388607);
    q_signed   = sq_q ? (~dvd_q[23:0] + 24'd1) : dvd_q[23:0];
    rem_signed = sdvd_q ? (~prem_q + 12'd1) : prem_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    sdvd_d  = sdvd_q;
    sq_d    = sq_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d   = din0[35] ? (~din0 + 36'd1) : din0;
          dvs_d   = din1[11] ? (~din1 + 12'd1) : din1;
          sdvd_d  = din0[35];
          sq_d    = din0[35] ^ din1[11];
          prem_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (cnt_q != Steps) begin
          prem_d = sub_ok ? (shifted[11:0] - dvs_q) : shifted[11:0];
          dvd_d  = {dvd_q[34:0], sub_ok};
          cnt_d  = cnt_q + 6'd1;
        end else begin
          if (dvs_q == 12'd0) begin
            dout_d = sdvd_q ? QMin : QMax;
            rem_d  = '0;
            ovf_d  = 1'b0;
            dz_d   = 1'b1;
          end else if (q_ovf) begin
            dout_d = sq_q ? QMin : QMax;
            rem_d  = '0;
            ovf_d  = 1'b1;
            dz_d   = 1'b0;
          end else begin
            dout_d = q_signed;
            rem_d  = rem_signed;
            ovf_d  = 1'b0;
            dz_d   = 1'b0;
          end
          done_d  = 1'b1;
          state_d = StFin;
        end
      end
      StFin: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      sdvd_q  <= 1'b0;
      sq_q    <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      sdvd_q  <= sdvd_d;
      sq_q    <= sq_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign dout = dout_q;
  assign rem  = rem_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: doc/fir_fixed_sdiv_36s_12s_24_seq.md
FIR_FIXED_SDIV_36S_12S_24_SEQ -- requirements
Module: fir_fixed_sdiv_36s_12s_24_seq

Interface
REQ-001 SHALL have parameter ID, default 32'd1, instance identifier with no functional effect.
REQ-002 SHALL have parameter din0_WIDTH, default 32'd36, dividend width; only 36 is supported.
REQ-003 SHALL have parameter din1_WIDTH, default 32'd12, divisor width; only 12 is supported.
REQ-004 SHALL have parameter dout_WIDTH, default 32'd24, quotient width; only 24 is supported.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port ce, input, 1, clock enable; when 0, all state, including outputs, SHALL hold.
REQ-008 SHALL have port start, input, 1, request to begin a division; sampled only when ce=1.
REQ-009 SHALL have port din0, input, 36, signed two's-complement dividend.
REQ-010 SHALL have port din1, input, 12, signed two's-complement divisor.
REQ-011 SHALL have port dout, output, 24, signed quotient, registered.
REQ-012 SHALL have port rem, output, 12, signed remainder, registered.
REQ-013 SHALL have port busy, output, 1, high from the start-accept edge until the done cycle ends.
REQ-014 SHALL have port done, output, 1, one ce-cycle pulse; dout, rem, ovf and dz are valid while it is high.
REQ-015 SHALL have port ovf, output, 1, quotient saturated.
REQ-016 SHALL have port dz, output, 1, divide by zero.

Function
REQ-017 SHALL implement FSM states IDLE, CALC and FIN; all transitions occur only on edges with ce=1.
REQ-018 IDLE with start=1: SHALL latch |din0| as a 36-bit unsigned value, |din1| as 12-bit unsigned, sign(din0) and sign(din0)^sign(din1); clear the iteration counter; set busy=1; go to CALC.
REQ-019 CALC: SHALL perform one restoring-division step per ce-cycle, shifting one dividend bit into the partial remainder, subtracting the divisor when the difference is non-negative, and shifting in the quotient bit.
REQ-020 CALC: after exactly 36 steps SHALL go to FIN; the counter SHALL be 6 bits and SHALL never wrap during an operation.
REQ-021 FIN: SHALL apply signs and saturation, register dout, rem, ovf and dz, set done=1 for one ce-cycle, clear busy at the end of that cycle, and return to IDLE.
REQ-022 Latency: start accepted on edge T SHALL produce done=1 in the cycle after edge T+37, counting ce=1 edges only.
REQ-023 Quotient SHALL truncate toward zero; rem SHALL carry the sign of the dividend (or be zero) and SHALL satisfy din0 = q*din1 + rem whenever ovf=0 and dz=0.
REQ-024 Signed quotient outside [-8388608, 8388607]: SHALL output dout=0x7FFFFF if positive or 0x800000 if negative, set ovf=1, and set rem=0.
REQ-025 A result of exactly -8388608 SHALL NOT set ovf.
REQ-026 din1=0: SHALL still take full latency; dout SHALL be 0x7FFFFF for din0>=0 or 0x800000 for din0<0; rem=0, dz=1, ovf=0.
REQ-027 start while busy=1 SHALL be ignored, with no effect on the current operation.
REQ-028 start in the same cycle as done=1 SHALL be ignored; a new start is accepted from IDLE only.
REQ-029 din0 and din1 SHALL be sampled only on the accept edge; later changes SHALL have no effect.
REQ-030 dout, rem, ovf and dz SHALL hold their last values after done until the next FIN.
REQ-031 ce=0 during CALC or FIN SHALL stretch latency by exactly the number of ce=0 cycles; done SHALL stay high while ce=0 in FIN.

Reset
REQ-032 reset=1 SHALL take priority over ce and start.
REQ-033 reset=1 SHALL set state=IDLE and counter=0, and force dout, rem, busy, done, ovf and dz to 0 on the next edge.
REQ-034 Reset mid-operation SHALL abandon the division with no done pulse; a start after reset is released SHALL proceed normally.

Verification
REQ-035 din0=1000, din1=7, ce=1 -> done 38 edges after accept; dout=142, rem=6, ovf=0, dz=0.
REQ-036 din0=-1000, din1=7 -> dout=0xFFFF72 (-142), rem=0xFFA (-6); din0=-25165824, din1=3 -> dout=0x800000, ovf=0.
REQ-037 din0=2^30, din1=1 -> dout=0x7FFFFF, ovf=1, rem=0; din0=-2^35, din1=-1 -> dout=0x7FFFFF, ovf=1.
REQ-038 din0=5, din1=0 -> dout=0x7FFFFF, dz=1, rem=0; din0=-5, din1=0 -> dout=0x800000, dz=1.
REQ-039 ce held low 10 cycles at step 12 with start pulsed while busy -> done exactly 48 clocks after accept; result is for the original operands.
REQ-040 reset at step 20 -> next edge busy=0, done=0, dout=0; no done pulse; next start of 100/-9 -> dout=-11, rem=1.
